// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolutor job driver.
// Holds default widths, the FSM state enum and the job struct.
package conv_pkg;

    localparam int OP_W_DEF       = 6;
    localparam int RES_W_DEF      = 4;
    localparam int LATENCY_DEF    = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CAPTURE,
        HOLD
    } state_t;

    // Operand pair as it appears on the convolutor bus: {b, a}.
    typedef struct packed {
        logic [OP_W_DEF-1:0] b;
        logic [OP_W_DEF-1:0] a;
    } job_t;

endpackage

// File: rtl/conv_job_fifo.sv
// Synchronous job FIFO, power-of-2 depth, async active-high reset.
// Ports: clk, reset, push/wdata, pop/rdata, full, empty, count.
module conv_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/conv_job_driver.sv
// Host-side initiator for the AND-popcount convolutor: queues jobs,
// launches each one, waits LATENCY cycles and returns the result.
// Ports: clk, reset (async, high); job_valid/job_ready/job_a/job_b;
// conv_operands {B,A}, conv_start, conv_result; res_valid/res_ready/
// res_data; busy; mismatch. Optional CONV_CHECK_EN adds a result
// checker that sets the sticky mismatch flag.
module conv_job_driver
    import conv_pkg::*;
#(
    parameter int OP_W       = OP_W_DEF,
    parameter int RES_W      = RES_W_DEF,
    parameter int LATENCY    = LATENCY_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [OP_W-1:0]   job_a,
    input  logic [OP_W-1:0]   job_b,
    output logic [2*OP_W-1:0] conv_operands,
    output logic              conv_start,
    input  logic [RES_W-1:0]  conv_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              busy,
    output logic              mismatch
);

    localparam int JW   = 2 * OP_W;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int CNTW = $clog2(LATENCY + 1);

    state_t            state_q;
    state_t            state_d;
    logic [CNTW-1:0]   cnt_q;
    logic [CNTW-1:0]   cnt_d;
    logic [JW-1:0]     ops_q;
    logic [JW-1:0]     ops_d;
    logic              load_ops;
    logic [RES_W-1:0]  res_data_q;
    logic              res_valid_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic [JW-1:0]     fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    assign job_ready = !fifo_full;
    assign fifo_push = job_valid && job_ready;
    assign fifo_pop  = (state_q == CAPTURE);

    conv_job_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (JW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({job_b, job_a}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A HOLD->LAUNCH taken on a same-cycle push into an empty FIFO
    // has no head yet, so the incoming job is forwarded directly.
    assign ops_d = fifo_empty ? {job_b, job_a} : fifo_rdata;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_ops = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d  = LAUNCH;
                    load_ops = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
                cnt_d   = CNTW'(LATENCY - 1);
            end
            WAIT: begin
                if (cnt_q == '0) state_d = CAPTURE;
                else             cnt_d   = cnt_q - CNTW'(1);
            end
            CAPTURE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    if (!fifo_empty || fifo_push) begin
                        state_d  = LAUNCH;
                        load_ops = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ops_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_ops) ops_q <= ops_d;
            if (state_q == CAPTURE) begin
                res_data_q  <= conv_result;
                res_valid_q <= 1'b1;
            end else if (res_valid_q && res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    // The convolutor is held in reset whenever the driver is.
    assign conv_start    = reset || (state_q == LAUNCH);
    assign conv_operands = ops_q;
    assign res_valid     = res_valid_q;
    assign res_data      = res_data_q;
    assign busy          = (state_q != IDLE) || (fifo_count != '0);

`ifdef CONV_CHECK_EN
    logic [RES_W-1:0] ref_res;
    logic             mismatch_q;

    always_comb begin
        ref_res = '0;
        for (int i = 0; i < OP_W; i++) begin
            ref_res = ref_res + RES_W'(ops_q[i] & ops_q[OP_W+i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch_q <= 1'b0;
        end else if (state_q == CAPTURE && conv_result != ref_res) begin
            mismatch_q <= 1'b1;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule
